// File: rtl/scanline_scheduler.sv
// scanline_scheduler: sorts one triangle by y, then walks its scanlines,
// presenting each edge pair and row to draw_line over a start/done handshake.
module scanline_scheduler #(
  parameter int FRAC  = 5,
  parameter int Y_MAX = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [15:0] v1x,
  input  logic [15:0] v1y,
  input  logic [15:0] v1z,
  input  logic [15:0] v2x,
  input  logic [15:0] v2y,
  input  logic [15:0] v2z,
  input  logic [15:0] v3x,
  input  logic [15:0] v3y,
  input  logic [15:0] v3z,
  output logic        line_start,
  input  logic        line_done,
  output logic [15:0] y_coord,
  output logic [15:0] pax,
  output logic [15:0] pay,
  output logic [15:0] paz,
  output logic [15:0] pbx,
  output logic [15:0] pby,
  output logic [15:0] pbz,
  output logic [15:0] pcx,
  output logic [15:0] pcy,
  output logic [15:0] pcz,
  output logic [15:0] pdx,
  output logic [15:0] pdy,
  output logic [15:0] pdz,
  output logic        tri_done,
  output logic        busy
);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vtx_t;

  typedef enum logic [2:0] {
    IDLE, SORT, SETUP, ISSUE, RELEASE, NEXT, FINISH
  } state_t;

  localparam logic [15:0] YMAX = 16'(Y_MAX);

  state_t      state_q, state_d;
  vtx_t        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  vtx_t        p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  vtx_t        pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
  logic [15:0] y_q, y_d;

  vtx_t        s1, s2, s3;
  logic [15:0] y_first, y_mid, y_top, y_last, y_load;
  logic        lower;

  // Three-element bubble network; strict compares keep equal-y input order.
  always_comb begin : sort3
    vtx_t t;
    s1 = v1_q;
    s2 = v2_q;
    s3 = v3_q;
    t  = s1;
    if (s1.y > s2.y) begin t = s1; s1 = s2; s2 = t; end
    if (s2.y > s3.y) begin t = s2; s2 = s3; s3 = t; end
    if (s1.y > s2.y) begin t = s1; s1 = s2; s2 = t; end
  end

  assign y_first = p1_q.y >> FRAC;
  assign y_mid   = p2_q.y >> FRAC;
  assign y_top   = p3_q.y >> FRAC;
  assign y_last  = (y_top > YMAX) ? YMAX : y_top;
  assign y_load  = (state_q == SETUP) ? y_first : y_q + 16'd1;
  assign lower   = y_load < y_mid;

  always_comb begin
    state_d = state_q;
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    pa_d = pa_q;
    pb_d = pb_q;
    pc_d = pc_q;
    pd_d = pd_q;
    y_d  = y_q;
    unique case (state_q)
      IDLE: begin
        if (tri_valid) begin
          v1_d    = {v1x, v1y, v1z};
          v2_d    = {v2x, v2y, v2z};
          v3_d    = {v3x, v3y, v3z};
          state_d = SORT;
        end
      end
      SORT: begin
        p1_d    = s1;
        p2_d    = s2;
        p3_d    = s3;
        state_d = SETUP;
      end
      SETUP, NEXT: begin
        if (state_q == SETUP && y_first > YMAX) begin
          state_d = FINISH;
        end else begin
          y_d     = y_load;
          pa_d    = p1_q;
          pb_d    = p3_q;
          pc_d    = lower ? p1_q : p2_q;
          pd_d    = lower ? p2_q : p3_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (line_done) state_d = RELEASE;
      end
      RELEASE: begin
        if (!line_done) state_d = (y_q == y_last) ? FINISH : NEXT;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      v1_q <= '0;
      v2_q <= '0;
      v3_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
      pa_q <= '0;
      pb_q <= '0;
      pc_q <= '0;
      pd_q <= '0;
      y_q  <= '0;
    end else begin
      state_q <= state_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
      pa_q <= pa_d;
      pb_q <= pb_d;
      pc_q <= pc_d;
      pd_q <= pd_d;
      y_q  <= y_d;
    end
  end

  assign tri_ready  = (state_q == IDLE) & ~reset;
  assign line_start = (state_q == ISSUE);
  assign tri_done   = (state_q == FINISH);
  assign busy       = (state_q != IDLE);
  assign y_coord    = y_q;
  assign {pax, pay, paz} = pa_q;
  assign {pbx, pby, pbz} = pb_q;
  assign {pcx, pcy, pcz} = pc_q;
  assign {pdx, pdy, pdz} = pd_q;

endmodule

// File: tb/tb_scanline_scheduler.sv
// Bench for scanline_scheduler: a y-sorted scanline list model, a randomised
// draw_line responder, and a per-cycle checker of the handshake and bundles.
module tb_scanline_scheduler;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vtx_t;

  typedef struct packed {
    logic [15:0] y;
    vtx_t a;
    vtx_t b;
    vtx_t c;
    vtx_t d;
  } exp_t;

  logic clk, reset, tri_valid, tri_ready, line_start, line_done;
  logic tri_done, busy;
  logic [15:0] v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
  logic [15:0] y_coord;
  logic [15:0] pax, pay, paz, pbx, pby, pbz;
  logic [15:0] pcx, pcy, pcz, pdx, pdy, pdz;

  scanline_scheduler dut (
    .clk(clk), .reset(reset),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v1x(v1x), .v1y(v1y), .v1z(v1z),
    .v2x(v2x), .v2y(v2y), .v2z(v2z),
    .v3x(v3x), .v3y(v3y), .v3z(v3z),
    .line_start(line_start), .line_done(line_done),
    .y_coord(y_coord),
    .pax(pax), .pay(pay), .paz(paz),
    .pbx(pbx), .pby(pby), .pbz(pbz),
    .pcx(pcx), .pcy(pcy), .pcz(pcz),
    .pdx(pdx), .pdy(pdy), .pdz(pdz),
    .tri_done(tri_done), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_rise, n_done, first_rise, acc_cyc;
  exp_t exp_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic vtx_t vt(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  function automatic exp_t cur();
    return {y_coord, pax, pay, paz, pbx, pby, pbz,
            pcx, pcy, pcz, pdx, pdy, pdz};
  endfunction

  // Rank each vertex by (y, input position), then list every covered row.
  task automatic build(input vtx_t a, input vtx_t b, input vtx_t c);
    vtx_t in[3];
    vtx_t p[3];
    int yf, ym, yl, r;
    in[0] = a;
    in[1] = b;
    in[2] = c;
    for (int i = 0; i < 3; i++) begin
      r = 0;
      for (int j = 0; j < 3; j++)
        if (in[j].y < in[i].y || (in[j].y == in[i].y && j < i)) r++;
      p[r] = in[i];
    end
    yf = int'(p[0].y) / 32;
    ym = int'(p[1].y) / 32;
    yl = int'(p[2].y) / 32;
    if (yl > 479) yl = 479;
    exp_q.delete();
    for (int y = yf; y <= yl; y++)
      exp_q.push_back({16'(y), p[0], p[2],
                       (y < ym) ? p[0] : p[1],
                       (y < ym) ? p[1] : p[2]});
  endtask

  // draw_line stand-in: done after 1-20 cycles, held 1-5 cycles past start.
  initial begin
    int d, h, k;
    line_done = 0;
    forever begin
      @(negedge clk);
      if (line_start && !line_done && !reset) begin
        d = $urandom_range(1, 20);
        for (int i = 1; i < d && line_start; i++) @(negedge clk);
        if (line_start) begin
          line_done = 1;
          k = 0;
          while (line_start && k < 100) begin
            @(negedge clk);
            k++;
          end
          h = $urandom_range(1, 5);
          repeat (h) @(negedge clk);
          line_done = 0;
        end
      end
    end
  end

  initial begin
    logic prev_start;
    exp_t snap, e;
    prev_start = 0;
    snap = '0;
    forever begin
      @(posedge clk);
      #1;
      if (line_start && !prev_start) begin
        chk("done_low_at_rise", line_done, 0);
        n_rise++;
        if (first_rise < 0) first_rise = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_line: got y=%0d want none", y_coord);
        end else begin
          e = exp_q.pop_front();
          chk("line_bundle", cur(), e);
        end
        snap = cur();
      end else if (line_start) begin
        chk("bundle_stable", cur(), snap);
      end
      if (tri_done) begin
        n_done++;
        chk("lines_left_at_done", exp_q.size(), 0);
      end
      prev_start = line_start;
    end
  end

  task automatic accept(input vtx_t a, input vtx_t b, input vtx_t c);
    @(negedge clk);
    n_rise = 0;
    n_done = 0;
    first_rise = -1;
    {v1x, v1y, v1z} = a;
    {v2x, v2y, v2z} = b;
    {v3x, v3y, v3z} = c;
    tri_valid = 1;
    chk("ready_before_accept", tri_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    @(negedge clk);
    tri_valid = 0;
  endtask

  task automatic run_tri(input vtx_t a, input vtx_t b, input vtx_t c);
    int n;
    n = exp_q.size();
    accept(a, b, c);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (tri_done) break;
    end
    chk("tri_done_seen", tri_done, 1);
    if (n == 0) chk("done_latency", cyc - acc_cyc, 2);
    @(posedge clk);
    #1;
    chk("done_one_pulse", tri_done, 0);
    chk("ready_after_done", tri_ready, 1);
    chk("idle_after_done", busy, 0);
    chk("line_count", n_rise, n);
    chk("done_count", n_done, 1);
    if (n > 0) chk("start_latency", first_rise - acc_cyc, 2);
  endtask

  vtx_t fa, fb, fc;

  initial begin
    reset = 1;
    tri_valid = 0;
    {v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z} = '0;
    n_rise = 0;
    n_done = 0;
    first_rise = -1;
    acc_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line_start", line_start, 0);
    chk("rst_tri_done", tri_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_low", tri_ready, 0);
    chk("rst_bundle", cur(), 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_ready_after", tri_ready, 1);

    fa = vt(320, 320, 0);
    fb = vt(160, 640, 0);
    fc = vt(480, 640, 0);
    build(fa, fb, fc);
    chk("model_flat_n", exp_q.size(), 11);
    chk("model_flat_y0", exp_q[0].y, 10);
    chk("model_y19_cd", {exp_q[9].c, exp_q[9].d},
        {16'd320, 16'd320, 16'd0, 16'd160, 16'd640, 16'd0});
    chk("model_y20_cd", {exp_q[10].c, exp_q[10].d},
        {16'd160, 16'd640, 16'd0, 16'd480, 16'd640, 16'd0});
    run_tri(fa, fb, fc);

    build(fb, fa, fc);
    chk("model_perm_same", exp_q[10], {16'd20, fa, fc, fb, fc});
    run_tri(fb, fa, fc);

    build(fc, fa, fb);
    chk("model_perm_pb", exp_q[0].b, {16'd160, 16'd640, 16'd0});
    run_tri(fc, fa, fb);

    build(vt(100, 15040, 1), vt(200, 16000, 2), vt(50, 15500, 3));
    chk("model_clip_n", exp_q.size(), 10);
    chk("model_clip_last", exp_q[9].y, 479);
    run_tri(vt(100, 15040, 1), vt(200, 16000, 2), vt(50, 15500, 3));

    build(vt(10, 15680, 0), vt(20, 15700, 0), vt(30, 16000, 0));
    chk("model_offscreen_n", exp_q.size(), 0);
    run_tri(vt(10, 15680, 0), vt(20, 15700, 0), vt(30, 16000, 0));

    build(vt(10, 96, 1), vt(50, 96, 2), vt(90, 96, 3));
    chk("model_row_n", exp_q.size(), 1);
    chk("model_row_cd", {exp_q[0].c, exp_q[0].d},
        {16'd50, 16'd96, 16'd2, 16'd90, 16'd96, 16'd3});
    run_tri(vt(10, 96, 1), vt(50, 96, 2), vt(90, 96, 3));

    build(vt(0, 320, 0), vt(100, 960, 0), vt(200, 640, 0));
    accept(vt(0, 320, 0), vt(100, 960, 0), vt(200, 640, 0));
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (line_start && y_coord == 16'd15) break;
    end
    chk("reach_y15_start", line_start, 1);
    chk("reach_y15_y", y_coord, 15);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrst_line_start", line_start, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    #1;
    chk("midrst_ready", tri_ready, 1);
    repeat (10) @(negedge clk);

    build(fa, fb, fc);
    run_tri(fa, fb, fc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
